// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the datapath/memory port.
// The master side is the sequencer; the slave side is the datapath and memory.
interface multicycle_ctrl_if #(
  parameter int INSTRET_W = 16
);
  logic                 start;
  logic [5:0]           opcode;
  logic                 alu_cond;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 mem_we;
  logic                 iord;
  logic                 ir_we;
  logic                 pc_we;
  logic [1:0]           pc_src;
  logic                 reg_we;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 alu_src_b;
  logic                 zero_ext;
  logic                 halted;
  logic                 illegal;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  start, opcode, alu_cond, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_b, zero_ext, halted, illegal, instret
  );

  modport slave (
    output start, opcode, alu_cond, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_b, zero_ext, halted, illegal, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; ALU 4, lw 5, sw 4, branch 3, j 2 cycles.
// Memory stalls hold FETCH/MEM with mem_req high until mem_ready; outputs decode combinationally.
module multicycle_ctrl #(
  parameter int INSTRET_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT, TRAP
  } state_t;

  state_t               state;
  logic [INSTRET_W-1:0] instret_q;

  logic is_alu, is_lw, is_sw, is_br, is_j, is_halt;
  logic retire, op_valid;

  assign is_alu  = bus.opcode inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd9, 6'd10, 6'd11};
  assign is_lw   = (bus.opcode == 6'd7);
  assign is_sw   = (bus.opcode == 6'd8);
  assign is_br   = (bus.opcode[5:3] == 3'b010);
  assign is_j    = (bus.opcode == 6'd24);
  assign is_halt = (bus.opcode == 6'd63);

  // The cycle an instruction leaves its final state.
  assign retire = (state == DECODE && is_j)
               || (state == MEM && bus.mem_ready && !is_lw)
               || (state == WB)
               || (state == BRANCH);

  // Opcode is only meaningful once IR has been loaded.
  assign op_valid = state inside {DECODE, EXEC, MEM, WB, BRANCH};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      instret_q <= '0;
    end else begin
      case (state)
        IDLE:   if (bus.start) state <= FETCH;
        FETCH:  if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          if (is_alu || is_lw || is_sw) state <= EXEC;
          else if (is_br)               state <= BRANCH;
          else if (is_j)                state <= FETCH;
          else if (is_halt)             state <= HALT;
          else                          state <= TRAP;
        end
        EXEC:   state <= (is_lw || is_sw) ? MEM : WB;
        MEM:    if (bus.mem_ready) state <= is_lw ? WB : FETCH;
        WB:     state <= FETCH;
        BRANCH: state <= FETCH;
        HALT:   state <= HALT;
        TRAP:   state <= TRAP;
        default: state <= IDLE;
      endcase
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 2'd0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_we   = bus.mem_ready;
        bus.pc_we   = bus.mem_ready;
      end
      DECODE: begin
        if (is_j) begin
          bus.pc_we  = 1'b1;
          bus.pc_src = 2'd2;
        end
      end
      MEM: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        bus.mem_we  = is_sw;
      end
      WB: begin
        bus.reg_we     = 1'b1;
        bus.reg_dst    = (bus.opcode == 6'd0);
        bus.mem_to_reg = is_lw;
      end
      BRANCH: begin
        bus.pc_src = 2'd1;
        bus.pc_we  = bus.alu_cond;
      end
      default: ;
    endcase
  end

  assign bus.alu_src_b = op_valid && (bus.opcode != 6'd0) && !is_br;
  assign bus.zero_ext  = op_valid && (bus.opcode inside {6'd2, 6'd3, 6'd4, 6'd5, 6'd11});
  assign bus.halted    = (state == HALT);
  assign bus.illegal   = (state == TRAP);
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each instruction class,
// stalls, HALT/TRAP, instret wrap on a 4-bit instance, and asynchronous reset.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.INSTRET_W(16)) b16 ();
  multicycle_ctrl_if #(.INSTRET_W(4))  b4 ();

  assign b4.start     = b16.start;
  assign b4.opcode    = b16.opcode;
  assign b4.alu_cond  = b16.alu_cond;
  assign b4.mem_ready = b16.mem_ready;

  multicycle_ctrl #(.INSTRET_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(b16));
  multicycle_ctrl #(.INSTRET_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  // {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, alu_src_b, zero_ext, halted, illegal}
  logic [13:0] ctl;
  assign ctl = {b16.mem_req, b16.mem_we, b16.iord, b16.ir_we, b16.pc_we, b16.pc_src,
                b16.reg_we, b16.reg_dst, b16.mem_to_reg, b16.alu_src_b, b16.zero_ext,
                b16.halted, b16.illegal};

  localparam logic [13:0] MREQ  = 14'h2000;
  localparam logic [13:0] MWE   = 14'h1000;
  localparam logic [13:0] IORD  = 14'h0800;
  localparam logic [13:0] IRWE  = 14'h0400;
  localparam logic [13:0] PCWE  = 14'h0200;
  localparam logic [13:0] PCS2  = 14'h0100;
  localparam logic [13:0] PCS1  = 14'h0080;
  localparam logic [13:0] REGWE = 14'h0040;
  localparam logic [13:0] RDST  = 14'h0020;
  localparam logic [13:0] M2R   = 14'h0010;
  localparam logic [13:0] SRCB  = 14'h0008;
  localparam logic [13:0] ZEXT  = 14'h0004;
  localparam logic [13:0] HLT   = 14'h0002;
  localparam logic [13:0] ILL   = 14'h0001;
  localparam logic [13:0] FETCH_RDY = MREQ | IRWE | PCWE;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_is(input string tag, input logic [13:0] exp);
    #1;
    check(tag, 32'(ctl), 32'(exp));
  endtask

  initial begin
    b16.start     = 1'b0;
    b16.opcode    = 6'd0;
    b16.alu_cond  = 1'b0;
    b16.mem_ready = 1'b1;
    #2;
    ctl_is("reset_ctl", 14'h0);
    check("reset_instret", 32'(b16.instret), 0);
    check("reset_instret4", 32'(b4.instret), 0);
    tick();
    rst_n = 1'b1;
    tick();
    ctl_is("idle_ignores_ready", 14'h0);

    // add: FETCH, DECODE, EXEC, WB
    b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    ctl_is("add_fetch", FETCH_RDY);
    tick(); ctl_is("add_decode", 14'h0);
    tick(); ctl_is("add_exec", 14'h0);
    tick(); ctl_is("add_wb", REGWE | RDST);
    check("add_instret_before", 32'(b16.instret), 0);
    tick(); ctl_is("add_next_fetch", FETCH_RDY);
    check("add_instret", 32'(b16.instret), 1);

    // lw with three MEM wait cycles: 8 cycles in total
    b16.opcode = 6'd7;
    tick(); ctl_is("lw_decode", SRCB);
    tick(); ctl_is("lw_exec", SRCB);
    b16.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ctl_is("lw_mem_wait", MREQ | IORD | SRCB);
      tick();
    end
    b16.mem_ready = 1'b1;
    ctl_is("lw_mem_done", MREQ | IORD | SRCB);
    tick(); ctl_is("lw_wb", REGWE | M2R | SRCB);
    tick(); ctl_is("lw_next_fetch", FETCH_RDY);
    check("lw_instret", 32'(b16.instret), 2);

    // sw
    b16.opcode = 6'd8;
    tick(); ctl_is("sw_decode", SRCB);
    tick(); ctl_is("sw_exec", SRCB);
    tick(); ctl_is("sw_mem", MREQ | MWE | IORD | SRCB);
    tick(); ctl_is("sw_next_fetch", FETCH_RDY);
    check("sw_instret", 32'(b16.instret), 3);

    // beq taken / not taken
    b16.opcode = 6'd16;
    b16.alu_cond = 1'b1;
    tick(); ctl_is("beq_t_decode", 14'h0);
    tick(); ctl_is("beq_t_branch", PCWE | PCS1);
    tick(); ctl_is("beq_t_next_fetch", FETCH_RDY);
    check("beq_t_instret", 32'(b16.instret), 4);
    b16.alu_cond = 1'b0;
    tick(); ctl_is("beq_n_decode", 14'h0);
    tick(); ctl_is("beq_n_branch", PCS1);
    tick(); ctl_is("beq_n_next_fetch", FETCH_RDY);
    check("beq_n_instret", 32'(b16.instret), 5);

    // j: two cycles
    b16.opcode = 6'd24;
    tick(); ctl_is("j_decode", PCWE | PCS2 | SRCB);
    tick(); ctl_is("j_next_fetch", FETCH_RDY);
    check("j_instret", 32'(b16.instret), 6);

    // ori: zero-extended immediate, rt destination
    b16.opcode = 6'd3;
    tick(); ctl_is("ori_decode", SRCB | ZEXT);
    tick(); ctl_is("ori_exec", SRCB | ZEXT);
    tick(); ctl_is("ori_wb", REGWE | SRCB | ZEXT);
    tick(); ctl_is("ori_next_fetch", FETCH_RDY);
    check("ori_instret", 32'(b16.instret), 7);

    // illegal opcode 6 traps and does not retire
    b16.opcode = 6'd6;
    tick();
    tick(); ctl_is("trap", ILL);
    for (int i = 0; i < 3; i++) begin
      b16.start = ~b16.start;
      tick();
      ctl_is("trap_holds", ILL);
    end
    b16.start = 1'b0;
    check("trap_instret", 32'(b16.instret), 7);
    rst_n = 1'b0;
    ctl_is("trap_reset_ctl", 14'h0);
    check("trap_reset_instret", 32'(b16.instret), 0);
    tick();
    rst_n = 1'b1;
    tick();
    ctl_is("trap_reset_idle", 14'h0);

    // halt
    b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    b16.opcode = 6'd63;
    tick();
    tick(); ctl_is("halt", HLT);
    for (int i = 0; i < 3; i++) begin
      b16.start = ~b16.start;
      tick();
      ctl_is("halt_holds", HLT);
    end
    b16.start = 1'b0;
    check("halt_instret", 32'(b16.instret), 0);
    rst_n = 1'b0;
    ctl_is("halt_reset_ctl", 14'h0);
    tick();
    rst_n = 1'b1;
    tick();
    ctl_is("halt_reset_idle", 14'h0);

    // 16 addi: 4-bit counter wraps, 16-bit counter reaches 16
    b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    b16.opcode = 6'd1;
    for (int i = 0; i < 16; i++) begin
      tick(); tick(); tick(); tick();
      if (i == 14) check("wrap_instret4_15", 32'(b4.instret), 15);
    end
    check("wrap_instret4", 32'(b4.instret), 0);
    check("wrap_instret16", 32'(b16.instret), 16);

    // reset during a FETCH wait drops mem_req without a clock edge
    b16.mem_ready = 1'b0;
    tick();
    ctl_is("fetch_wait", MREQ);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mem_req", 32'(b16.mem_req), 0);
    check("async_reset_instret", 32'(b16.instret), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing FSM for the mini-processor datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and arbitrates the single memory port between instruction fetch and data access with a req/ready handshake. It also drives the PC, IR, register-file and memory enables. ALU operation selection stays in the existing opcode/func ALU decoder; this block only sequences the datapath around it.

## Interface
- `INSTRET_W`, default 16: width of the retired-instruction counter.
- `clk` in, 1 bit: clock; all state changes on the rising edge.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `start` in, 1 bit: leave IDLE and begin fetching.
- `opcode` in, 6 bits: IR[31:26], valid from DECODE onward.
- `alu_cond` in, 1 bit: ALU result bit 0; compare outcome for branches.
- `mem_ready` in, 1 bit: memory completes the current access this cycle.
- `mem_req` out, 1 bit: memory access request.
- `mem_we` out, 1 bit: memory write.
- `iord` out, 1 bit: memory address select; 0 = PC, 1 = ALU result register.
- `ir_we` out, 1 bit: load IR.
- `pc_we` out, 1 bit: load PC.
- `pc_src` out, 2 bits: PC source; 0 = PC+1, 1 = branch target, 2 = jump target.
- `reg_we` out, 1 bit: register-file write.
- `reg_dst` out, 1 bit: 1 = rd, 0 = rt.
- `mem_to_reg` out, 1 bit: writeback data; 1 = memory data register, 0 = ALU result register.
- `alu_src_b` out, 1 bit: ALU B input; 1 = extended immediate, 0 = rt.
- `zero_ext` out, 1 bit: 1 = zero-extend immediate, 0 = sign-extend.
- `halted` out, 1 bit: in HALT.
- `illegal` out, 1 bit: in TRAP.
- `instret` out, `INSTRET_W` bits: retired-instruction count.

## Operation
- Opcode classes:
  - ALU class: R-type 0, addi 1, andi 2, ori 3, xori 4, addui 5, slti 9, seq 10, lui 11.
  - Memory: lw 7, sw 8.
  - Branches: 16–23.
  - Jump: j 24.
  - Halt: 63.
  - Any other opcode is illegal.
- `zero_ext` = 1 for opcodes 2, 3, 4, 5 and 11; otherwise 0.
- `alu_src_b` = 1 for every non-R-type, non-branch instruction.
- State transitions:
  - IDLE: on `start`, go to FETCH.
  - FETCH:
    - Drive `mem_req`=1, `iord`=0 and hold them until `mem_ready`.
    - In the `mem_ready` cycle, also drive `ir_we`=1, `pc_we`=1, `pc_src`=0, then go to DECODE.
  - DECODE, one cycle:
    - ALU class, lw or sw: go to EXEC.
    - Branch: go to BRANCH.
    - j: drive `pc_we`=1, `pc_src`=2, retire, go to FETCH.
    - Halt: go to HALT.
    - Illegal: go to TRAP.
  - EXEC, one cycle (ALU result register captures): lw/sw go to MEM; the ALU class goes to WB.
  - MEM:
    - Drive `mem_req`=1, `iord`=1 and `mem_we` = (opcode==8), held until `mem_ready`.
    - On `mem_ready`: lw goes to WB; sw retires and goes to FETCH.
  - WB, one cycle:
    - Drive `reg_we`=1.
    - `reg_dst` = (opcode==0); `mem_to_reg` = (opcode==7).
    - Retire, go to FETCH.
  - BRANCH, one cycle:
    - Drive `pc_src`=1 and `pc_we` = `alu_cond`.
    - Retire, go to FETCH.
  - HALT and TRAP: absorbing; only `rst_n` exits.
- Retire: `instret` increments by 1 on the cycle the instruction leaves its last state. It wraps from 2^`INSTRET_W`−1 to 0. Halt and illegal opcodes do not retire.
- `start` is ignored outside IDLE.

## Timing
- Reset, asynchronous: state = IDLE and `instret` = 0. Every output is 0, including `pc_src`=0.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronously). The access is abandoned and nothing is written.
- Output decoding:
  - Outputs are combinational from state and opcode.
  - `ir_we`, the FETCH `pc_we`, and the MEM→next transition additionally depend on `mem_ready` in the same cycle.
  - The BRANCH `pc_we` depends on `alu_cond` in the same cycle.
- Latency with zero wait states (`mem_ready` high whenever `mem_req` is high):
  - ALU class: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch: 3 cycles.
  - j: 2 cycles.
  - Each wait cycle in FETCH or MEM adds 1.
- `mem_ready` while `mem_req`=0 is ignored.
- `opcode` only needs to be stable from DECODE to the end of the instruction. IR loads only in FETCH.

## Test plan
- Reset, then `start`=1 for 1 cycle, `mem_ready`=1, opcode 0 (add) → FETCH/DECODE/EXEC/WB over 4 cycles. WB shows `reg_we`=1 and `reg_dst`=1, and `instret`=1.
- lw (7) with `mem_ready` held low 3 cycles in MEM → `mem_req`=1 and `iord`=1 held 4 cycles. WB shows `mem_to_reg`=1; total 8 cycles. sw (8) → `mem_we`=1 in MEM and no `reg_we`.
- beq (16) with `alu_cond`=1 → `pc_we`=1, `pc_src`=1 in BRANCH. With `alu_cond`=0 → `pc_we`=0. Both cases retire.
- j (24) → `pc_we`=1, `pc_src`=2 in DECODE; next cycle is FETCH; 2 cycles total.
- Opcode 63 → `halted`=1 and stays, with `start` toggling ignored. Opcode 6 → `illegal`=1, `instret` unchanged. Assert `rst_n`=0 → both clear and state returns to IDLE.
- `INSTRET_W`=4, 16 addi instructions → `instret` wraps to 0. Assert `rst_n` low mid-FETCH wait → `mem_req`=0 in the same cycle.
